// File: rtl/cmp_share_arbiter.sv
// -----------------------------------------------------------------------------
// cmp_share_arbiter
//   Shares one registered W-bit unsigned magnitude comparator among NREQ
//   requesters. A round-robin arbiter grants one requester at a time, the
//   granted operand pair is compared for one cycle, and the LT/GT/EQ result is
//   presented on a single response channel tagged with the requester id.
//   Only one pair is in flight at a time.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   req_valid  [NREQ]      requester i holds a valid operand pair
//   req_ready  [NREQ]      one-hot grant (or zero), combinational in IDLE
//   req_a      [NREQ*W]    operand A of requester i at [i*W +: W]
//   req_b      [NREQ*W]    operand B of requester i at [i*W +: W]
//   rsp_valid  response valid
//   rsp_ready  response consumer ready
//   rsp_id     [IDW]       index of the requester the response belongs to
//   rsp_lt/gt/eq           A<B / A>B / A==B, held until the response is taken
// -----------------------------------------------------------------------------
module cmp_share_arbiter #(
  parameter  int NREQ = 4,
  parameter  int W    = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_lt,
  output logic              rsp_gt,
  output logic              rsp_eq
);

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t          state, state_n;
  logic [IDW-1:0]  rr_ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [IDW-1:0]  scan_idx;

  logic [W-1:0]    op_a_p0;
  logic [W-1:0]    op_b_p0;
  logic [IDW-1:0]  id_p0;

  // Three-way unsigned compare, packed as {lt, gt, eq}; exactly one bit set.
  function automatic logic [2:0] cmp3(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2:0] r;
    r = 3'b000;
    if (a < b)      r = 3'b100;
    else if (a > b) r = 3'b010;
    else            r = 3'b001;
    return r;
  endfunction

  // Round-robin search starting at rr_ptr; first valid index wins.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    grant    = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_any && req_valid[scan_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = scan_idx;
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (gnt_any) state_n = CMP;
      end
      CMP:     state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (rst) req_ready = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      id_p0     <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_lt    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
    end else begin
      // Stage p0: capture the granted pair; operands are only sampled here.
      if (state == IDLE && gnt_any) begin
        op_a_p0 <= req_a[int'(gnt_idx)*W +: W];
        op_b_p0 <= req_b[int'(gnt_idx)*W +: W];
        id_p0   <= gnt_idx;
      end
      // Stage p1: registered compare result becomes the response.
      if (state == CMP) begin
        {rsp_lt, rsp_gt, rsp_eq} <= cmp3(op_a_p0, op_b_p0);
        rsp_id    <= id_p0;
        rsp_valid <= 1'b1;
      end
      // Response taken: pointer moves past the requester just served.
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= (id_p0 == IDW'(NREQ-1)) ? '0 : id_p0 + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
module tb_cmp_share_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic        rsp_lt, rsp_gt, rsp_eq;

  cmp_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_lt(rsp_lt), .rsp_gt(rsp_gt), .rsp_eq(rsp_eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int id3_cnt = 0;
  int grants_seen[$];
  int grant_cyc[$];

  // Reference model: one transaction in flight, result visible after the
  // compare cycle, pointer moves past the served requester on completion.
  bit m_busy;
  int m_wait;
  int m_id, m_a, m_b;
  int m_rr;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  task automatic cycle(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                       input logic rdy);
    int g;
    @(negedge clk);
    req_valid = v; req_a = a; req_b = b; rsp_ready = rdy;
    #1;
    g = m_busy ? -1 : pick(v, m_rr);
    check("req_ready", int'(req_ready), (g < 0) ? 0 : (1 << g));
    check("rsp_valid", int'(rsp_valid), int'(m_busy && m_wait == 0));
    if (m_busy && m_wait == 0) begin
      check("rsp_id", int'(rsp_id), m_id);
      check("rsp_lt", int'(rsp_lt), int'(m_a < m_b));
      check("rsp_gt", int'(rsp_gt), int'(m_a > m_b));
      check("rsp_eq", int'(rsp_eq), int'(m_a == m_b));
    end
    if (req_ready != 4'b0000) begin
      for (int i = 0; i < NREQ; i++)
        if (req_ready[i]) begin grants_seen.push_back(i); grant_cyc.push_back(cyc); end
    end
    if (rsp_valid && rsp_id == 2'd3) id3_cnt++;
    @(posedge clk);
    cyc++;
    if (!m_busy) begin
      if (g >= 0) begin
        m_busy = 1'b1; m_wait = 1; m_id = g;
        m_a = int'(a[g*W +: W]); m_b = int'(b[g*W +: W]);
      end
    end else if (m_wait > 0) begin
      m_wait--;
    end else if (rdy) begin
      m_busy = 1'b0;
      m_rr = (m_id + 1) % NREQ;
    end
  endtask

  task automatic do_reset(input logic [3:0] v_during);
    @(negedge clk);
    req_valid = v_during;
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_req_ready", int'(req_ready), 0);
    m_busy = 1'b0; m_wait = 0; m_rr = 0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic txn(input int idx, input logic [3:0] a, input logic [3:0] b);
    logic [15:0] av, bv;
    int n;
    av = 16'($urandom); bv = 16'($urandom);
    av[idx*W +: W] = a; bv[idx*W +: W] = b;
    cycle(4'(1 << idx), av, bv, 1'b1);
    n = 0;
    while (m_busy && n < 10) begin
      cycle(4'b0000, 16'($urandom), 16'($urandom), 1'b1);
      n++;
    end
    if (m_busy) check("txn_timeout", 1, 0);
  endtask

  initial begin
    int base;
    rst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_busy = 0; m_wait = 0; m_rr = 0; m_id = 0; m_a = 0; m_b = 0;
    #2 rst = 1'b1;
    #1;
    check("init_rsp_valid", int'(rsp_valid), 0);
    check("init_req_ready", int'(req_ready), 0);
    do_reset(4'b1111);
    #1;
    check("init_rsp_id", int'(rsp_id), 0);
    check("init_rsp_ltgteq", int'({rsp_lt, rsp_gt, rsp_eq}), 0);

    // T2: single request from requester 2, 9 vs 3
    cycle(4'b0100, 16'h0900, 16'h0300, 1'b1);
    cycle(4'b0000, 16'h0, 16'h0, 1'b0);
    cycle(4'b0000, 16'h0, 16'h0, 1'b0);
    check("t2_id", int'(rsp_id), 2);
    check("t2_gt", int'({rsp_lt, rsp_gt, rsp_eq}), 3'b010);
    cycle(4'b0000, 16'h0, 16'h0, 1'b1);

    // T1: reset while a response is pending
    cycle(4'b0001, 16'h0005, 16'h0006, 1'b0);
    cycle(4'b0000, 16'h0, 16'h0, 1'b0);
    cycle(4'b0000, 16'h0, 16'h0, 1'b0);
    check("t1_pending", int'(rsp_valid), 1);
    do_reset(4'b1111);
    #1;
    check("t1_cleared_flags", int'({rsp_lt, rsp_gt, rsp_eq}), 0);
    base = grants_seen.size();
    cycle(4'b1010, 16'h0, 16'h0, 1'b1);
    check("t1_first_grant_cnt", grants_seen.size() - base, 1);
    if (grants_seen.size() > base) check("t1_first_grant", grants_seen[base], 1);
    cycle(4'b0000, 16'h0, 16'h0, 1'b1);
    cycle(4'b0000, 16'h0, 16'h0, 1'b1);

    // T3: all valid, consumer always ready
    do_reset(4'b0000);
    base = grants_seen.size();
    for (int i = 0; i < 13; i++) cycle(4'b1111, 16'($urandom), 16'($urandom), 1'b1);
    check("t3_count", grants_seen.size() - base, 5);
    if (grants_seen.size() - base >= 5) begin
      for (int i = 0; i < 5; i++) check("t3_order", grants_seen[base+i], i % NREQ);
      for (int i = 1; i < 5; i++)
        check("t3_spacing", grant_cyc[base+i] - grant_cyc[base+i-1], 3);
    end
    while (m_busy) cycle(4'b0000, 16'h0, 16'h0, 1'b1);

    // T4: backpressure in RESP
    cycle(4'b0001, 16'h000A, 16'h000A, 1'b0);
    cycle(4'b0000, 16'h0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b1111, 16'($urandom), 16'($urandom), 1'b0);
    base = grants_seen.size();
    cycle(4'b1111, 16'h0, 16'h0, 1'b1);
    cycle(4'b1111, 16'h0, 16'h0, 1'b1);
    check("t4_idle_grant", grants_seen.size() - base, 1);
    while (m_busy) cycle(4'b0000, 16'h0, 16'h0, 1'b1);

    // T5: boundary operands, then every pair on requester 1
    txn(0, 4'hF, 4'hF);
    txn(2, 4'h0, 4'hF);
    txn(3, 4'hF, 4'h0);
    txn(1, 4'h7, 4'h8);
    txn(0, 4'h8, 4'h7);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) txn(1, 4'(a), 4'(b));

    // T6: requester 3 appears only while busy and leaves before IDLE
    id3_cnt = 0;
    base = grants_seen.size();
    cycle(4'b0001, 16'h0003, 16'h0004, 1'b0);
    cycle(4'b1000, 16'h0, 16'h0, 1'b0);
    cycle(4'b1000, 16'h0, 16'h0, 1'b0);
    cycle(4'b1000, 16'h0, 16'h0, 1'b0);
    cycle(4'b0000, 16'h0, 16'h0, 1'b1);
    cycle(4'b0001, 16'h0, 16'h0, 1'b1);
    while (m_busy) cycle(4'b0000, 16'h0, 16'h0, 1'b1);
    check("t6_id3_rsp", id3_cnt, 0);
    for (int i = base; i < grants_seen.size(); i++) check("t6_grant_not3", int'(grants_seen[i] == 3), 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++)
      cycle(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
